component_label_engine: RTL and testbench
=========================================

Name: component_label_engine

Overview:
- Connected-component labeling engine for a 32x32 binary image.
- Reads the packed 1-bit image from an external synchronous 128x8 ROM.
- Writes one 8-bit label per pixel into an external synchronous 1024x8 SRAM (background 0; each 8-connected object gets its own non-zero label).
- Raises finish when the SRAM image is complete; sits between the image ROM and result SRAM with both chip-enables tied active.

Parameters:
- None; image size 32x32, ROM 128x8 and SRAM 1024x8 are fixed.

Ports:
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-low reset
- rom_q  input  8  ROM read data, valid the cycle after rom_a is sampled
- rom_a  output  7  ROM byte address
- sram_q  input  8  SRAM read data, valid the cycle after sram_a is sampled (read when sram_wen=1)
- sram_a  output  10  SRAM word address
- sram_d  output  8  SRAM write data
- sram_wen  output  1  SRAM write enable, active-low; write occurs at the rising edge where it is 0
- finish  output  1  completion flag

Behaviour:
- Reset (reset=0 at a rising edge):
  - rom_a=0, sram_a=0, sram_d=0, sram_wen=1, finish=0.
  - FSM returns to IDLE and clears the equivalence table.
  - Reset mid-operation aborts and restarts from pixel 0 after release.
- Image mapping:
  - Pixel (row r, col c) lives in ROM byte r*4+c/8, bit 7-(c%8) (MSB = leftmost). 1 = object, 0 = background.
  - SRAM word r*32+c holds the final label of that pixel.
- Memory timing: ROM and SRAM are registered-read with 1-cycle latency. The engine must budget that latency and never sample rom_q/sram_q early.
- Connectivity: 8-neighbour. Diagonally touching pixels belong to the same object.
- Algorithm (two-pass with equivalence table):
  - Pass 1 (raster order, r then c):
    - Fetch each ROM byte once and shift out 8 pixels.
    - Background pixel: write 0.
    - Object pixel:
      - Examine already-labelled neighbours W, NW, N, NE; read from SRAM or from an internal line buffer of the previous row (32x6 bits).
      - If none are labelled, allocate the next provisional label (1..63).
      - Otherwise use the smallest root among the neighbours and record union(root_a, root_b) for every differing neighbour root. The smaller root always becomes the parent.
  - Resolve: flatten the 64-entry parent table so every entry points to its root.
  - Pass 2: for addr 0..1023, read SRAM. If the word is non-zero, write back parent[word]; zero words are not rewritten.
- Labels:
  - Final labels are non-zero and ≤63.
  - Identical within one object and distinct between objects.
  - Label values need not be consecutive.
- Capacity: at most 63 provisional labels. Images needing more produce undefined labels but must still terminate and assert finish.
- Writes:
  - All 1024 SRAM words must be written at least once in pass 1; no word may be left unwritten.
  - sram_wen is 0 for exactly one cycle per write, with sram_a/sram_d stable in that cycle.
- FSM states: IDLE -> P1_FETCH -> P1_PIXEL (loop over 8 bits, 128 bytes) -> RESOLVE (64 entries) -> P2_READ -> P2_WAIT -> P2_WRITE (loop 1024) -> DONE.
  - IDLE is left on the first cycle after reset release.
- finish:
  - Goes 1 in DONE, one cycle after the final SRAM write edge.
  - Holds 1 with sram_wen=1 until reset; no memory writes after finish.
- Total latency: below 12000 cycles from reset release.

Test Plan:
- All-zero ROM (128 x 0x00) -> all 1024 SRAM words 0x00; finish rises once; no further writes.
- ROM byte0=0x80, others 0 -> sram[0]≠0, sram[1..1023]=0.
- Pixels (0,0) and (1,1) set (byte0=0x80, byte4=0x40) -> sram[0]==sram[33]≠0, all else 0 (diagonal merge).
- U-shape (two vertical bars cols 2 and 6, rows 0-9, joined by row 9) -> every bar pixel has one identical label, so late-merge equivalence resolves in pass 2.
- Five disjoint blobs, including an NE-diagonal staircase and a blob touching col 31/row 31 -> five distinct non-zero labels, each consistent within its blob, background 0.
- Reset asserted for one cycle mid-pass-1, then released -> finish stays 0 until the full rerun completes; final SRAM contents match the undisturbed result.

Source files
------------

// File: rtl/component_label_engine.sv
// component_label_engine: two-pass 8-connected component labeling of a 32x32
// binary image read from a 128x8 ROM, writing one label per pixel to a 1024x8 SRAM.
`default_nettype none

module component_label_engine (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rom_q,
  output logic [6:0] rom_a,
  input  logic [7:0] sram_q,
  output logic [9:0] sram_a,
  output logic [7:0] sram_d,
  output logic       sram_wen,
  output logic       finish
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_P1_FETCH = 3'd1,
    S_P1_PIXEL = 3'd2,
    S_RESOLVE  = 3'd3,
    S_P2_READ  = 3'd4,
    S_P2_WAIT  = 3'd5,
    S_P2_WRITE = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t     r_state;
  logic [9:0] r_pix;
  logic [5:0] r_next;
  logic [5:0] r_w;
  logic [5:0] r_prevn;
  logic [5:0] r_ridx;
  logic [5:0] r_parent [64];
  logic [5:0] r_lb     [32];

  logic [4:0] w_col;
  logic       w_row0;
  logic       w_bit;
  logic [5:0] w_lw, w_lnw, w_ln, w_lne;
  logic [5:0] w_roots [4];
  logic [5:0] w_min;
  logic       w_any;
  logic [5:0] w_label;
  logic       w_merge;

  assign w_col  = r_pix[4:0];
  assign w_row0 = (r_pix[9:5] == 5'd0);
  assign w_bit  = rom_q[3'd7 - r_pix[2:0]];

  // The line buffer slot for the current column is overwritten as the row
  // advances, so the NW label is carried in r_prevn from the previous column.
  assign w_lw  = (w_col == 5'd0) ? 6'd0 : r_w;
  assign w_lnw = (w_row0 || w_col == 5'd0) ? 6'd0 : r_prevn;
  assign w_ln  = w_row0 ? 6'd0 : r_lb[w_col];
  assign w_lne = (w_row0 || w_col == 5'd31) ? 6'd0 : r_lb[w_col + 5'd1];

  always_comb begin
    w_roots[0] = r_parent[w_lw];
    w_roots[1] = r_parent[w_lnw];
    w_roots[2] = r_parent[w_ln];
    w_roots[3] = r_parent[w_lne];
    w_min = 6'h3f;
    w_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (w_roots[k] != 6'd0) begin
        w_any = 1'b1;
        if (w_roots[k] < w_min) w_min = w_roots[k];
      end
    end
  end

  assign w_label = !w_bit ? 6'd0 : (w_any ? w_min : r_next);
  assign w_merge = w_bit & w_any;

  always_ff @(posedge clk) begin
    if (reset && r_state == S_P1_PIXEL) r_lb[w_col] <= w_label;
  end

  // The parent table is kept flat during pass 1: a union relinks every entry
  // of the absorbed roots straight to the smallest root in one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      rom_a    <= 7'd0;
      sram_a   <= 10'd0;
      sram_d   <= 8'd0;
      sram_wen <= 1'b1;
      finish   <= 1'b0;
      r_pix    <= 10'd0;
      r_next   <= 6'd1;
      r_w      <= 6'd0;
      r_prevn  <= 6'd0;
      r_ridx   <= 6'd0;
      for (int i = 0; i < 64; i++) r_parent[i] <= 6'(i);
    end else begin
      case (r_state)
        S_IDLE: begin
          rom_a   <= 7'd0;
          r_state <= S_P1_FETCH;
        end
        S_P1_FETCH: begin
          sram_wen <= 1'b1;
          r_state  <= S_P1_PIXEL;
        end
        S_P1_PIXEL: begin
          sram_a   <= r_pix;
          sram_d   <= {2'b00, w_label};
          sram_wen <= 1'b0;
          r_w      <= w_label;
          r_prevn  <= r_lb[w_col];
          if (w_bit && !w_any && r_next != 6'd63) r_next <= r_next + 6'd1;
          if (w_merge) begin
            for (int i = 1; i < 64; i++) begin
              if (r_parent[i] == w_roots[0] || r_parent[i] == w_roots[1] ||
                  r_parent[i] == w_roots[2] || r_parent[i] == w_roots[3])
                r_parent[i] <= w_min;
            end
          end
          r_pix <= r_pix + 10'd1;
          if (r_pix[2:0] == 3'd7) begin
            rom_a   <= rom_a + 7'd1;
            r_state <= (r_pix == 10'd1023) ? S_RESOLVE : S_P1_FETCH;
          end
        end
        S_RESOLVE: begin
          sram_wen         <= 1'b1;
          r_parent[r_ridx] <= r_parent[r_parent[r_ridx]];
          r_ridx           <= r_ridx + 6'd1;
          if (r_ridx == 6'd63) r_state <= S_P2_READ;
        end
        S_P2_READ: begin
          sram_a   <= r_pix;
          sram_wen <= 1'b1;
          r_state  <= S_P2_WAIT;
        end
        S_P2_WAIT: begin
          r_state <= S_P2_WRITE;
        end
        S_P2_WRITE: begin
          if (sram_q != 8'd0) begin
            sram_d   <= {2'b00, r_parent[sram_q[5:0]]};
            sram_wen <= 1'b0;
          end
          r_pix   <= r_pix + 10'd1;
          r_state <= (r_pix == 10'd1023) ? S_DONE : S_P2_READ;
        end
        S_DONE: begin
          sram_wen <= 1'b1;
          finish   <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_component_label_engine.sv
// tb_component_label_engine: directed images checked against a flood-fill
// reference partition plus per-cycle write-protocol checks.
`default_nettype none

module tb_component_label_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rom_q = 8'd0;
  logic [6:0] rom_a;
  logic [7:0] sram_q = 8'd0;
  logic [9:0] sram_a;
  logic [7:0] sram_d;
  logic       sram_wen;
  logic       finish;

  component_label_engine dut (
    .clk(clk), .reset(rst_n), .rom_q(rom_q), .rom_a(rom_a),
    .sram_q(sram_q), .sram_a(sram_a), .sram_d(sram_d),
    .sram_wen(sram_wen), .finish(finish)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [128];
  logic [7:0] mem [1024];
  logic       img [1024];
  int         comp [1024];
  int         stk [1024];
  int         ncomp;
  logic       written [1024];
  logic       fin_seen;
  logic       rst_edge;
  int         total = 0;
  int         bad = 0;

  always @(posedge clk) begin
    rom_q  <= rom[rom_a];
    sram_q <= mem[sram_a];
    if (!sram_wen) mem[sram_a] <= sram_d;
    rst_edge <= !rst_n;
  end

  // Per-cycle protocol checks against the reference image.
  always @(negedge clk) begin
    if (!rst_n) begin
      fin_seen <= 1'b0;
      for (int p = 0; p < 1024; p++) written[p] <= 1'b0;
      if (rst_edge) begin
        total = total + 1;
        if (rom_a != 7'd0 || sram_a != 10'd0 || sram_d != 8'd0 || sram_wen != 1'b1 || finish != 1'b0) begin
          bad = bad + 1;
          $display("FAIL reset_values: rom_a=%0d sram_a=%0d sram_d=%0d wen=%0d finish=%0d, want 0 0 0 1 0",
                   rom_a, sram_a, sram_d, sram_wen, finish);
        end
      end
    end else begin
      if (fin_seen) begin
        total = total + 1;
        if (!finish) begin
          bad = bad + 1;
          $display("FAIL finish_hold: finish=0 after it had risen, want 1");
        end
      end
      if (finish) fin_seen <= 1'b1;
      if (!sram_wen) begin
        total = total + 1;
        if (finish || sram_d > 8'd63) begin
          bad = bad + 1;
          $display("FAIL write_legal: addr=%0d data=%0d finish=%0d, want finish=0 data<=63",
                   sram_a, sram_d, finish);
        end
        total = total + 1;
        if (!written[sram_a]) begin
          if ((sram_d != 8'd0) != img[sram_a]) begin
            bad = bad + 1;
            $display("FAIL p1_write: addr=%0d data=%0d, want nonzero=%0d", sram_a, sram_d, img[sram_a]);
          end
          written[sram_a] <= 1'b1;
        end else if (sram_d == 8'd0 || !img[sram_a]) begin
          bad = bad + 1;
          $display("FAIL p2_write: addr=%0d data=%0d pixel=%0d, want nonzero rewrite of object pixel",
                   sram_a, sram_d, img[sram_a]);
        end
      end
    end
  end

  task automatic clear_img();
    for (int p = 0; p < 1024; p++) img[p] = 1'b0;
  endtask

  task automatic set_px(input int r, input int c);
    img[r*32 + c] = 1'b1;
  endtask

  task automatic load_rom();
    for (int b = 0; b < 128; b++)
      for (int k = 0; k < 8; k++) rom[b][7-k] = img[b*8 + k];
    for (int p = 0; p < 1024; p++) mem[p] = 8'hEE;
  endtask

  // Reference partition by flood fill over 8-neighbours.
  task automatic compute_model();
    int sp, q, nr, nc, n;
    for (int p = 0; p < 1024; p++) comp[p] = 0;
    ncomp = 0;
    for (int p = 0; p < 1024; p++) begin
      if (img[p] && comp[p] == 0) begin
        ncomp++;
        comp[p] = ncomp;
        sp = 0;
        stk[sp] = p; sp++;
        while (sp > 0) begin
          sp--; q = stk[sp];
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
              nr = q / 32 + dr; nc = q % 32 + dc;
              if (nr >= 0 && nr < 32 && nc >= 0 && nc < 32) begin
                n = nr*32 + nc;
                if (img[n] && comp[n] == 0) begin
                  comp[n] = ncomp; stk[sp] = n; sp++;
                end
              end
            end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_finish(input string name);
    int cyc;
    cyc = 0;
    while (!finish && cyc < 12000) begin
      tick(); cyc++;
    end
    total = total + 1;
    if (!finish) begin
      bad = bad + 1;
      $display("FAIL %s_latency: finish not seen after %0d cycles, want < 12000", name, cyc);
    end
  endtask

  task automatic start_run();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic check_result(input string name);
    int lab [1025];
    int missing;
    for (int k = 0; k <= 1024; k++) lab[k] = -1;
    missing = 0;
    for (int p = 0; p < 1024; p++) begin
      if (!written[p]) missing++;
      total = total + 1;
      if (!img[p]) begin
        if (mem[p] != 8'd0) begin
          bad = bad + 1;
          $display("FAIL %s_bg: sram[%0d]=%0d, want 0", name, p, mem[p]);
        end
      end else if (mem[p] == 8'd0 || mem[p] > 8'd63) begin
        bad = bad + 1;
        $display("FAIL %s_range: sram[%0d]=%0d, want 1..63", name, p, mem[p]);
      end else if (lab[comp[p]] == -1) begin
        lab[comp[p]] = int'(mem[p]);
      end else if (lab[comp[p]] != int'(mem[p])) begin
        bad = bad + 1;
        $display("FAIL %s_consistent: sram[%0d]=%0d, want %0d", name, p, mem[p], lab[comp[p]]);
      end
    end
    for (int a = 1; a <= ncomp; a++)
      for (int b = a + 1; b <= ncomp; b++) begin
        total = total + 1;
        if (lab[a] != -1 && lab[a] == lab[b]) begin
          bad = bad + 1;
          $display("FAIL %s_distinct: objects %0d and %0d share label %0d, want distinct", name, a, b, lab[a]);
        end
      end
    total = total + 1;
    if (missing != 0) begin
      bad = bad + 1;
      $display("FAIL %s_coverage: %0d words never written, want 0", name, missing);
    end
  endtask

  task automatic run_case(input string name);
    load_rom();
    compute_model();
    start_run();
    wait_finish(name);
    repeat (6) tick();
    @(negedge clk);
    total = total + 1;
    if (finish !== 1'b1 || sram_wen !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL %s_done_hold: finish=%0d wen=%0d, want 1 1", name, finish, sram_wen);
    end
    check_result(name);
  endtask

  task automatic lit(input string name, input int got, input int want, input bit eq);
    total = total + 1;
    if ((got == want) != eq) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d, want %s%0d", name, got, eq ? "" : "not ", want);
    end
  endtask

  initial begin
    int distinct;
    logic seen [256];

    clear_img();
    run_case("zeros");
    lit("zeros_ncomp", ncomp, 0, 1'b1);
    lit("zeros_word0", int'(mem[0]), 0, 1'b1);

    clear_img(); set_px(0, 0);
    run_case("single");
    lit("single_word0", int'(mem[0]), 0, 1'b0);
    lit("single_word1", int'(mem[1]), 0, 1'b1);

    clear_img(); set_px(0, 0); set_px(1, 1);
    run_case("diag");
    lit("diag_rom4", int'(rom[4]), 8'h40, 1'b1);
    lit("diag_merge", int'(mem[33]), int'(mem[0]), 1'b1);
    lit("diag_nonzero", int'(mem[33]), 0, 1'b0);

    clear_img();
    for (int r = 0; r < 10; r++) begin set_px(r, 2); set_px(r, 6); end
    for (int c = 3; c < 6; c++) set_px(9, c);
    run_case("ushape");
    lit("ushape_ncomp", ncomp, 1, 1'b1);
    lit("ushape_tops", int'(mem[6]), int'(mem[2]), 1'b1);
    lit("ushape_nonzero", int'(mem[2]), 0, 1'b0);

    clear_img();
    set_px(0, 0); set_px(0, 1); set_px(1, 0); set_px(1, 1);
    set_px(5, 10); set_px(4, 11); set_px(3, 12); set_px(2, 13);
    set_px(31, 31); set_px(30, 31); set_px(31, 30);
    set_px(20, 6); set_px(21, 5); set_px(21, 7);
    set_px(20, 24); set_px(20, 26); set_px(21, 25);
    run_case("blobs");
    lit("blobs_ncomp", ncomp, 5, 1'b1);
    for (int v = 0; v < 256; v++) seen[v] = 1'b0;
    distinct = 0;
    for (int p = 0; p < 1024; p++)
      if (mem[p] != 8'd0 && !seen[mem[p]]) begin seen[mem[p]] = 1'b1; distinct++; end
    lit("blobs_distinct", distinct, 5, 1'b1);
    lit("blobs_stair", int'(mem[2*32+13]), int'(mem[5*32+10]), 1'b1);
    lit("blobs_vmerge", int'(mem[20*32+26]), int'(mem[20*32+24]), 1'b1);

    // Reset pulse partway through pass 1 with the U-shape image.
    clear_img();
    for (int r = 0; r < 10; r++) begin set_px(r, 2); set_px(r, 6); end
    for (int c = 3; c < 6; c++) set_px(9, c);
    load_rom();
    compute_model();
    start_run();
    repeat (400) tick();
    lit("midreset_finish_low", int'(finish), 0, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_finish("midreset");
    repeat (4) tick();
    check_result("midreset");
    lit("midreset_tops", int'(mem[6]), int'(mem[2]), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
